// File: rtl/pc_sequencer.sv
// pc_sequencer: two-state (FETCH/EXEC) program-counter sequencer.
//   FETCH requests imem at pc and latches the instruction on imem_ack.
//   EXEC presents the instruction to the decoder. When stall is low it
//   selects the next pc from muxPC and counts the instruction as retired.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   muxPC            next-pc select: 0=pc+4, 1=jump, 2=jr_addr, 3=branch
//   jr_addr          register target used when muxPC=2
//   stall            holds the current instruction in EXEC
//   imem_rdata/ack   instruction memory response (data valid with ack)
//   imem_req/addr    fetch request (FETCH only) and address (= pc)
//   pc, pc_plus4     current instruction address and pc+4
//   instr, opcode, functcode, instr_valid   instruction register and decode slices
//   retired          count of completed instructions (wraps)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  muxPC,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  functcode,
  output logic        instr_valid,
  output logic [31:0] retired
);

  typedef enum logic {FETCH, EXEC} state_t;
  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] br_off;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign functcode = instr[5:0];

  // Gated with reset so nothing is requested or decoded while reset is held,
  // even though the state register only clears at the next edge.
  assign imem_req    = (state == FETCH) && !reset;
  assign instr_valid = (state == EXEC)  && !reset;

  // Sign-extended word offset relative to the delay-slot-free pc+4.
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (muxPC)
      2'd0: next_pc = pc_plus4;
      2'd1: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'd2: next_pc = jr_addr;
      2'd3: next_pc = pc_plus4 + br_off;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      case (state)
        FETCH: if (imem_ack) begin
          instr <= imem_rdata;
          state <= EXEC;
        end
        EXEC: if (!stall) begin
          pc      <= next_pc;
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] ADDI   = 32'h2009_0005;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  muxPC = 2'd0;
  logic [31:0] jr_addr = '0;
  logic        stall = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr, pc, pc_plus4, instr, retired;
  logic [5:0]  opcode, functcode;
  logic        instr_valid;

  int nchk = 0;
  int errs = 0;
  logic [31:0] sbq[$];
  logic [31:0] mpc, minstr, mret;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .muxPC(muxPC), .jr_addr(jr_addr), .stall(stall),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
    .opcode(opcode), .functcode(functcode), .instr_valid(instr_valid),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH, 1 time unit after an edge. Pushes the expected next pc
  // when the EXEC exit is driven, pops it when the next FETCH appears.
  task automatic run_instr(input logic [31:0] w, input logic [1:0] m,
                           input logic [31:0] jr, input int stalls,
                           input int ackd, input logic [31:0] exp_next);
    logic [31:0] a0, i0, e;
    a0 = mpc;
    i0 = minstr;
    nchk++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== a0) begin
      errs++;
      $display("FAIL fetch_entry req=%b vld=%b addr=%h want req=1 vld=0 addr=%h", imem_req, instr_valid, imem_addr, a0);
    end
    for (int k = 0; k < ackd; k++) begin
      imem_ack = 1'b0;
      muxPC = 2'($urandom_range(3));
      stall = 1'($urandom_range(1));
      tick();
      nchk++;
      if (imem_req !== 1'b1 || imem_addr !== a0 || instr !== i0 || pc !== a0) begin
        errs++;
        $display("FAIL fetch_wait req=%b addr=%h instr=%h want req=1 addr=%h instr=%h", imem_req, imem_addr, instr, a0, i0);
      end
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    stall = 1'b0;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    minstr = w;
    nchk++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w ||
        opcode !== w[31:26] || functcode !== w[5:0] || pc_plus4 !== a0 + 32'd4) begin
      errs++;
      $display("FAIL exec_entry vld=%b req=%b instr=%h op=%h fn=%h p4=%h want instr=%h p4=%h", instr_valid, imem_req, instr, opcode, functcode, pc_plus4, w, a0 + 32'd4);
    end
    for (int k = 0; k < stalls; k++) begin
      stall = 1'b1;
      muxPC = 2'($urandom_range(3));
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      tick();
      nchk++;
      if (pc !== a0 || instr !== w || retired !== mret || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold pc=%h instr=%h ret=%0d vld=%b want pc=%h instr=%h ret=%0d vld=1", pc, instr, retired, instr_valid, a0, w, mret);
      end
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    muxPC = m;
    jr_addr = jr;
    sbq.push_back(exp_next);
    tick();
    muxPC = 2'($urandom_range(3));
    jr_addr = $urandom;
    mret = mret + 32'd1;
    e = sbq.pop_front();
    mpc = e;
    nchk++;
    if (imem_addr !== e || pc !== e || retired !== mret || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      errs++;
      $display("FAIL exec_exit addr=%h pc=%h ret=%0d vld=%b want addr=%h ret=%0d vld=0", imem_addr, pc, retired, instr_valid, e, mret);
    end
  endtask

  task automatic check_reset_state(input string nm);
    nchk++;
    if (pc !== RST_PC || instr !== 32'h0 || retired !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s pc=%h instr=%h ret=%0d req=%b vld=%b want pc=%h instr=0 ret=0 req=0 vld=0", nm, pc, instr, retired, imem_req, instr_valid, RST_PC);
    end
  endtask

  task automatic release_reset(input string nm);
    logic [31:0] e;
    reset = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    #1;
    sbq.delete();
    sbq.push_back(RST_PC);
    e = sbq.pop_front();
    mpc = e; minstr = '0; mret = '0;
    nchk++;
    if (imem_req !== 1'b1 || imem_addr !== e || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s req=%b addr=%h vld=%b want req=1 addr=%h vld=0", nm, imem_req, imem_addr, instr_valid, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b1; stall = 1'b1; muxPC = 2'd3; imem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    check_reset_state("reset_state");
    release_reset("reset_release");
  endtask

  task automatic test_back_to_back();
    run_instr(ADDI, 2'd0, 32'h0, 0, 0, 32'h0000_0004);
    run_instr(ADDI, 2'd0, 32'h0, 0, 0, 32'h0000_0008);
    run_instr(ADDI, 2'd0, 32'h0, 0, 0, 32'h0000_000C);
  endtask

  task automatic test_jump_branch();
    run_instr(ADDI,          2'd2, 32'h0000_0010, 0, 0, 32'h0000_0010);
    run_instr(32'h0800_0040, 2'd1, 32'h0,         0, 0, 32'h0000_0100);
    run_instr(ADDI,          2'd2, 32'h0000_0020, 0, 0, 32'h0000_0020);
    run_instr(32'h1109_FFFE, 2'd3, 32'h0,         0, 0, 32'h0000_001C);
    run_instr(ADDI,          2'd2, 32'h0000_0020, 0, 0, 32'h0000_0020);
    run_instr(32'h1109_0003, 2'd3, 32'h0,         0, 0, 32'h0000_0030);
    // Unaligned register target passes through untouched.
    run_instr(ADDI,          2'd2, 32'h0000_0123, 0, 0, 32'h0000_0123);
  endtask

  task automatic test_jr_stall();
    run_instr(ADDI, 2'd2, 32'h0000_0444, 3, 0, 32'h0000_0444);
  endtask

  task automatic test_ack_wait();
    run_instr(ADDI, 2'd0, 32'h0, 0, 4, 32'h0000_0448);
  endtask

  task automatic test_wrap();
    run_instr(ADDI, 2'd2, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC);
    run_instr(ADDI, 2'd0, 32'h0,         0, 0, 32'h0000_0000);
  endtask

  task automatic test_random();
    logic [31:0] w, jr, p4, nx;
    logic [1:0]  m;
    for (int n = 0; n < 24; n++) begin
      w  = $urandom;
      jr = $urandom;
      m  = 2'($urandom_range(3));
      p4 = mpc + 32'd4;
      case (m)
        2'd0: nx = p4;
        2'd1: nx = {p4[31:28], w[25:0], 2'b00};
        2'd2: nx = jr;
        default: nx = p4 + {{14{w[15]}}, w[15:0], 2'b00};
      endcase
      run_instr(w, m, jr, int'($urandom_range(2)), int'($urandom_range(2)), nx);
    end
  endtask

  task automatic test_reset_with_ack();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b0;
    #1;
    nchk++;
    if (imem_req !== 1'b0) begin
      errs++;
      $display("FAIL reset_req_gate req=%b want 0", imem_req);
    end
    tick();
    check_reset_state("reset_with_ack");
    release_reset("reset_with_ack_release");
  endtask

  task automatic test_reset_mid_exec();
    run_instr(ADDI, 2'd2, 32'h0000_0800, 0, 0, 32'h0000_0800);
    imem_ack = 1'b1; imem_rdata = ADDI;
    tick();
    imem_ack = 1'b0;
    reset = 1'b1; stall = 1'b0; muxPC = 2'd0;
    #1;
    nchk++;
    if (instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_vld_gate vld=%b want 0", instr_valid);
    end
    tick();
    check_reset_state("reset_mid_exec");
    release_reset("reset_mid_exec_release");
    run_instr(ADDI, 2'd0, 32'h0, 0, 0, RST_PC + 32'd4);
  endtask

  initial begin
    mpc = RST_PC; minstr = '0; mret = '0;
    test_reset();
    test_back_to_back();
    test_jump_branch();
    test_jr_stall();
    test_ack_wait();
    test_wrap();
    test_random();
    test_reset_with_ack();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
    $finish;
  end

endmodule
